// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default link constants and the
// bit-period divider calculation used by both transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_REL
    } uart_state_t;

    localparam int DEFAULT_CLK_FREQ  = 100_000_000;
    localparam int DEFAULT_BAUD_RATE = 19_200;

    // Clock cycles per serial bit, truncated.
    function automatic int calcBitDiv(input int clkFreq, input int baudRate);
        return clkFreq / baudRate;
    endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: one-cycle tick every DIV enabled cycles. clr reloads the
// count with OFFSET (a receiver uses a half period to land mid-bit).
module baud_tick #(
    parameter int DIV    = 10,
    parameter int OFFSET = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(OFFSET);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!en) begin
            count <= '0;
        end else if (clr) begin
            count <= LOAD_VAL;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, stop bit.
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE = DEFAULT_BAUD_RATE,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] din,
    output logic                 tx,
    output logic                 busy
);

    localparam int BIT_DIV = calcBitDiv(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    // Handshake: send is a level request; it is accepted on a rising edge in
    // IDLE (busy rises on that edge), and the FSM re-arms only after send has
    // been seen low once the frame is complete, so a held request sends once.
    uart_state_t          state;
    logic [DATA_BITS-1:0] shiftReg;
    logic [IDX_W-1:0]     bitIdx;
    logic                 bitDone;
    logic                 accept;
    logic                 running;
`ifdef UART_TX_PARITY_EN
    logic                 parityBit;
`endif

    assign accept  = (state == IDLE) && send;
    assign running = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);

    baud_tick #(
        .DIV    (BIT_DIV),
        .OFFSET (0)
    ) baudGen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (running || accept),
        .clr   (accept),
        .tick  (bitDone)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            shiftReg <= '0;
            bitIdx   <= '0;
`ifdef UART_TX_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (send) begin
                        shiftReg <= din;
`ifdef UART_TX_PARITY_EN
                        parityBit <= ^din;
`endif
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        state <= START;
                    end else begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                START: begin
                    if (bitDone) begin
                        tx       <= shiftReg[0];
                        shiftReg <= shiftReg >> 1;
                        bitIdx   <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (bitDone) begin
                        if (bitIdx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parityBit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            // Shifting keeps the next bit at shiftReg[0].
                            tx       <= shiftReg[0];
                            shiftReg <= shiftReg >> 1;
                            bitIdx   <= bitIdx + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bitDone) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bitDone) begin
                        state <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (!send) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BIT_DIV=10; covers reset, framing, held and
// corrupted requests, asynchronous reset mid-frame and (if enabled) parity.
module tb_uart_tx;

    localparam int BIT_DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int BUSY_PULSE = 111;
    localparam logic [10:0] FR_A5 = 11'h54A;
    localparam logic [10:0] FR_3C = 11'h478;
    localparam logic [10:0] FR_00 = 11'h400;
`else
    localparam int FRAME_BITS = 10;
    localparam int BUSY_PULSE = 101;
    localparam logic [10:0] FR_A5 = 11'h34A;
    localparam logic [10:0] FR_3C = 11'h278;
    localparam logic [10:0] FR_00 = 11'h200;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       send  = 1'b0;
    logic [7:0] din   = 8'h00;
    logic       tx;
    logic       busy;

    int nChecks = 0;
    int nErrors = 0;
    logic [0:0] expQ[$];

    uart_tx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000),
        .DATA_BITS (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .send  (send),
        .din   (din),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // bits[i] is the i-th bit on the line. send is high for the first `hold`
    // sampling edges. busy stays high until the first edge after the frame
    // where send is low.
    task automatic runFrame(input logic [7:0] d, input logic [10:0] bits,
                            input int hold, input bit corrupt, input int expBusyLen);
        int frameLen;
        int idleEdge;
        int busyLen;
        logic [0:0] expBit;
        frameLen = FRAME_BITS * BIT_DIV;
        idleEdge = (hold > frameLen + 1) ? hold : frameLen + 1;
        busyLen  = 0;
        expBit   = 1'b1;
        expQ.delete();
        for (int i = 0; i < FRAME_BITS; i++) expQ.push_back(bits[i]);
        @(negedge clk);
        din  = d;
        send = 1'b1;
        for (int c = 0; c < idleEdge + 4; c++) begin
            @(negedge clk);
            if (c < frameLen) begin
                if (c % BIT_DIV == 0) expBit = expQ.pop_front();
                checkVal("tx_bit", 32'(tx), 32'(expBit));
            end else begin
                checkVal("tx_idle", 32'(tx), 32'd1);
            end
            checkVal("busy", 32'(busy), 32'(c < idleEdge));
            if (busy) busyLen++;
            if (c + 1 >= hold) send = 1'b0;
            if (corrupt && c == 0) din = ~d;
        end
        checkVal("busy_len", 32'(busyLen), 32'(expBusyLen));
    endtask

    initial begin
        // Reset held with send already requested: nothing may leave the pin.
        send = 1'b1;
        din  = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            checkVal("rst_tx", 32'(tx), 32'd1);
            checkVal("rst_busy", 32'(busy), 32'd0);
        end
        rst_n = 1'b1;
        send  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkVal("post_rst_tx", 32'(tx), 32'd1);
            checkVal("post_rst_busy", 32'(busy), 32'd0);
        end

        runFrame(8'hA5, FR_A5, 1, 1'b0, BUSY_PULSE);
        runFrame(8'h3C, FR_3C, 300, 1'b0, 300);
        runFrame(8'h00, FR_00, 1, 1'b1, BUSY_PULSE);

        // Reset in the middle of data bit 3 (a 0 for 8'hA5).
        @(negedge clk);
        din  = 8'hA5;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (44) @(negedge clk);
        checkVal("tx_before_rst", 32'(tx), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        checkVal("tx_async_rst", 32'(tx), 32'd1);
        checkVal("busy_async_rst", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            checkVal("tx_after_rst", 32'(tx), 32'd1);
            checkVal("busy_after_rst", 32'(busy), 32'd0);
        end
        runFrame(8'hA5, FR_A5, 1, 1'b0, BUSY_PULSE);

`ifdef UART_TX_PARITY_EN
        runFrame(8'h07, 11'h60E, 1, 1'b0, BUSY_PULSE);
        runFrame(8'h03, 11'h406, 1, 1'b0, BUSY_PULSE);
`endif

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
